// File: rtl/img_pkg.sv
// Shared types and default geometry for the frame flip/invert sequencer.
package img_pkg;

    localparam int          DEF_IMG_W    = 320;
    localparam int          DEF_IMG_H    = 240;
    localparam int          DEF_DATA_W   = 32;
    localparam int          DEF_ADDR_W   = 17;
    localparam int          DEF_RD_LAT   = 1;
    localparam logic [31:0] DEF_INV_MASK = 32'h00FF_FFFF;

    localparam int PAIRS_PER_ROW = (DEF_IMG_W + 1) / 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } flip_state_t;

    function automatic int pairs_per_row(input int w);
        return (w + 1) / 2;
    endfunction

endpackage

// File: rtl/img_flip_addr_gen.sv
// Walks the frame one left/right pixel pair per step; row base kept as a running sum.
module img_flip_addr_gen
    import img_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    output logic [ADDR_W-1:0] addr_l,
    output logic [ADDR_W-1:0] addr_r,
    output logic              middle,
    output logic              last
);

    localparam int PAIRS = pairs_per_row(IMG_W);
    localparam int XW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [XW-1:0]     X_LAST   = XW'(PAIRS - 1);
    localparam logic [XW-1:0]     X_MID    = XW'(IMG_W / 2);
    localparam logic [YW-1:0]     Y_LAST   = YW'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ROW_END  = ADDR_W'(IMG_W - 1);
    localparam logic              ODD_W    = ((IMG_W % 2) == 1);

    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] row_base;
    logic              row_end;

    always_comb begin
        row_end = (x == X_LAST);
        last    = row_end && (y == Y_LAST);
        middle  = ODD_W && (x == X_MID);
        addr_l  = row_base + ADDR_W'(x);
        addr_r  = row_base + ROW_END - ADDR_W'(x);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
        end else if (step) begin
            if (row_end) begin
                x <= '0;
                if (last) begin
                    y        <= '0;
                    row_base <= '0;
                end else begin
                    y        <= y + 1'b1;
                    row_base <= row_base + ROW_STEP;
                end
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/img_flip_invert_ctrl.sv
// Mirrors each row left-to-right and XOR-inverts every pixel in one pass over the 2R/2W memory.
module img_flip_invert_ctrl
    import img_pkg::*;
#(
    parameter int                IMG_W    = DEF_IMG_W,
    parameter int                IMG_H    = DEF_IMG_H,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                RD_LAT   = DEF_RD_LAT,
    parameter logic [DATA_W-1:0] INV_MASK = DATA_W'(DEF_INV_MASK)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd0_en,
    output logic [ADDR_W-1:0] rd0_addr,
    input  logic [DATA_W-1:0] rd0_data,
    output logic              rd1_en,
    output logic [ADDR_W-1:0] rd1_addr,
    input  logic [DATA_W-1:0] rd1_data,
    output logic              wr0_en,
    output logic [ADDR_W-1:0] wr0_addr,
    output logic [DATA_W-1:0] wr0_data,
    output logic              wr1_en,
    output logic [ADDR_W-1:0] wr1_addr,
    output logic [DATA_W-1:0] wr1_data
);

    localparam int SW = 2 * ADDR_W + 2;
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'(RD_LAT - 1);

    flip_state_t        state;
    logic               issued_last;
    logic [CW-1:0]      drain_cnt;
    logic               step;
    logic [ADDR_W-1:0]  addr_l;
    logic [ADDR_W-1:0]  addr_r;
    logic               middle;
    logic               last;
    logic [SW-1:0]      cur;
    logic [RD_LAT*SW-1:0] dly_line;
    logic [SW-1:0]      tap;

    assign step = ((state == IDLE) && start) || ((state == RUN) && !issued_last);

    img_flip_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .step   (step),
        .addr_l (addr_l),
        .addr_r (addr_r),
        .middle (middle),
        .last   (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            issued_last <= 1'b0;
            drain_cnt   <= '0;
            rd0_en      <= 1'b0;
            rd0_addr    <= '0;
            rd1_en      <= 1'b0;
            rd1_addr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (issued_last) begin
                        state       <= DRAIN;
                        rd0_en      <= 1'b0;
                        rd1_en      <= 1'b0;
                        issued_last <= 1'b0;
                        drain_cnt   <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // The middle pixel of an odd row is read once on port 0 only.
            if (step) begin
                rd0_en      <= 1'b1;
                rd0_addr    <= addr_l;
                rd1_en      <= !middle;
                rd1_addr    <= addr_r;
                issued_last <= last;
            end
        end
    end

    assign cur = {rd0_en, rd1_en, rd0_addr, rd1_addr};

    generate
        if (RD_LAT == 1) begin : g_dly1
            always_ff @(posedge clk or posedge reset) begin
                if (reset) dly_line <= '0;
                else       dly_line <= cur;
            end
        end else begin : g_dlyn
            always_ff @(posedge clk or posedge reset) begin
                if (reset) dly_line <= '0;
                else       dly_line <= {dly_line[(RD_LAT-1)*SW-1:0], cur};
            end
        end
    endgenerate

    assign tap = dly_line[RD_LAT*SW-1 -: SW];

    // Left destination takes the right source, and vice versa; data gated so idle outputs stay 0.
    always_comb begin
        wr0_en   = tap[SW-1];
        wr1_en   = tap[SW-2];
        wr0_addr = tap[2*ADDR_W-1 -: ADDR_W];
        wr1_addr = tap[ADDR_W-1:0];
        wr0_data = '0;
        wr1_data = '0;
        if (wr0_en) wr0_data = (wr1_en ? rd1_data : rd0_data) ^ INV_MASK;
        if (wr1_en) wr1_data = rd0_data ^ INV_MASK;
    end

endmodule

// File: tb/tb_img_flip_invert_ctrl.sv
// Scoreboard bench: several frame geometries run side by side against a memory model and a mirror/invert reference.
module tb_img_flip_invert_ctrl;

    localparam int          NCFG = 5;
    localparam int          MEMN = 1 << 17;
    localparam logic [31:0] MASK = 32'h00FF_FFFF;

    function automatic int cfg_w(input int i);
        case (i) 0: return 4; 1: return 5; 2: return 4; 3: return 320; default: return 40; endcase
    endfunction
    function automatic int cfg_h(input int i);
        case (i) 0: return 2; 1: return 3; 2: return 2; 3: return 240; default: return 30; endcase
    endfunction
    function automatic int cfg_l(input int i);
        case (i) 0: return 1; 1: return 1; 2: return 3; 3: return 1; default: return 2; endcase
    endfunction
    function automatic bit cfg_rnd(input int i);
        return (i >= 3);
    endfunction
    function automatic bit cfg_two(input int i);
        return (i != 3);
    endfunction
    function automatic bit cfg_rst(input int i);
        return (i == 4);
    endfunction

    typedef struct packed {
        logic        en0;
        logic        en1;
        logic [16:0] a0;
        logic [16:0] a1;
    } rd_t;

    typedef struct packed {
        logic        en1;
        logic [16:0] a0;
        logic [31:0] d0;
        logic [16:0] a1;
        logic [31:0] d1;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int W    = cfg_w(g);
        localparam int H    = cfg_h(g);
        localparam int L    = cfg_l(g);
        localparam int NPIX = W * H;
        localparam int P    = (W + 1) / 2;
        localparam int NP   = P * H;

        logic        reset, start, busy, done;
        logic        rd0_en, rd1_en, wr0_en, wr1_en;
        logic [16:0] rd0_addr, rd1_addr, wr0_addr, wr1_addr;
        logic [31:0] rd0_data, rd1_data, wr0_data, wr1_data;

        logic [31:0] mem   [MEMN];
        logic [31:0] orig  [MEMN];
        logic [31:0] model [MEMN];
        logic [31:0] nxt   [MEMN];
        logic [31:0] p0    [L];
        logic [31:0] p1    [L];
        logic        load;

        int cyc = 0;
        int c0 = 0;
        int pass_id = 0;
        bit finished = 1'b0;

        rd_t rq[$];
        wr_t wq[$];

        int mon_id = 0;
        int done_cnt = 0;
        int done_rel = -1;
        int busy_cnt = 0;
        int busy_first = -1;

        img_flip_invert_ctrl #(
            .IMG_W    (W),
            .IMG_H    (H),
            .DATA_W   (32),
            .ADDR_W   (17),
            .RD_LAT   (L),
            .INV_MASK (MASK)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .start    (start),
            .busy     (busy),
            .done     (done),
            .rd0_en   (rd0_en),
            .rd0_addr (rd0_addr),
            .rd0_data (rd0_data),
            .rd1_en   (rd1_en),
            .rd1_addr (rd1_addr),
            .rd1_data (rd1_data),
            .wr0_en   (wr0_en),
            .wr0_addr (wr0_addr),
            .wr0_data (wr0_data),
            .wr1_en   (wr1_en),
            .wr1_addr (wr1_addr),
            .wr1_data (wr1_data)
        );

        // Pixel memory: two read ports with L-cycle latency, two write ports.
        always @(posedge clk) begin
            cyc <= cyc + 1;
            if (load) begin
                for (int i = 0; i < NPIX; i++) mem[i] <= orig[i];
            end else begin
                if (wr0_en) mem[wr0_addr] <= wr0_data;
                if (wr1_en) mem[wr1_addr] <= wr1_data;
            end
            for (int i = L - 1; i > 0; i--) begin
                p0[i] <= p0[i-1];
                p1[i] <= p1[i-1];
            end
            p0[0] <= rd0_en ? mem[rd0_addr] : 32'd0;
            p1[0] <= rd1_en ? mem[rd1_addr] : 32'd0;
        end
        assign rd0_data = p0[L-1];
        assign rd1_data = p1[L-1];

        always @(negedge clk) begin
            rd_t re;
            wr_t we;
            int  rel;
            if (mon_id != pass_id) begin
                mon_id     = pass_id;
                done_cnt   = 0;
                done_rel   = -1;
                busy_cnt   = 0;
                busy_first = -1;
            end
            rel = cyc - c0;
            if (!reset) begin
                if (busy) begin
                    busy_cnt++;
                    if (busy_first < 0) busy_first = rel;
                end
                if (done) begin
                    done_cnt++;
                    done_rel = rel;
                end
                if (rd0_en || rd1_en) begin
                    if (rq.size() == 0) begin
                        chk($sformatf("cfg%0d_read_unexpected", g), {rd0_en, rd1_en, rd0_addr}, '0);
                    end else begin
                        re = rq.pop_front();
                        chk($sformatf("cfg%0d_read", g),
                            {rd0_en, rd1_en, rd0_addr, rd1_en ? rd1_addr : 17'd0}, re);
                    end
                end
                if (wr0_en || wr1_en) begin
                    if (wq.size() == 0) begin
                        chk($sformatf("cfg%0d_write_unexpected", g), {wr0_en, wr1_en, wr0_addr}, '0);
                    end else begin
                        we = wq.pop_front();
                        chk($sformatf("cfg%0d_write", g),
                            {wr0_en, wr1_en, wr0_addr, wr0_data,
                             wr1_en ? wr1_addr : 17'd0, wr1_en ? wr1_data : 32'd0},
                            {1'b1, we});
                    end
                end
            end
        end

        task automatic load_frame();
            for (int i = 0; i < NPIX; i++) begin
                orig[i]  = cfg_rnd(g) ? $urandom : 32'(i);
                model[i] = orig[i];
            end
            load = 1'b1;
            @(negedge clk);
            load = 1'b0;
        endtask

        // Expected port traffic from the current model frame, then model <- mirrored and inverted frame.
        task automatic push_expect();
            rd_t r;
            wr_t w;
            for (int y = 0; y < H; y++) begin
                for (int x = 0; x < P; x++) begin
                    int al;
                    int ar;
                    bit mid;
                    al    = y * W + x;
                    ar    = y * W + (W - 1 - x);
                    mid   = (al == ar);
                    r.en0 = 1'b1;
                    r.en1 = !mid;
                    r.a0  = 17'(al);
                    r.a1  = mid ? 17'd0 : 17'(ar);
                    rq.push_back(r);
                    w.en1 = !mid;
                    w.a0  = 17'(al);
                    w.d0  = model[ar] ^ MASK;
                    w.a1  = mid ? 17'd0 : 17'(ar);
                    w.d1  = mid ? 32'd0 : (model[al] ^ MASK);
                    wq.push_back(w);
                end
            end
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    nxt[y * W + x] = model[y * W + (W - 1 - x)] ^ MASK;
            for (int i = 0; i < NPIX; i++) model[i] = nxt[i];
        endtask

        task automatic run_pass(input bit pulses, input int rst_at, output bit aborted);
            int last_t;
            last_t  = NP + L + 2;
            aborted = 1'b0;
            push_expect();
            pass_id++;
            c0    = cyc;
            start = 1'b1;
            for (int t = 1; t <= last_t; t++) begin
                @(negedge clk);
                start = pulses && (t == 3 || t == 100) && (t <= NP + L + 1);
                if (t == rst_at) begin
                    reset = 1'b1;
                    #1;
                    chk($sformatf("cfg%0d_reset_midpass", g),
                        {rd0_en, rd1_en, wr0_en, wr1_en, busy, done}, '0);
                    start   = 1'b0;
                    aborted = 1'b1;
                    return;
                end
            end
            start = 1'b0;
        endtask

        task automatic check_pass(input bit restore);
            int bad;
            chk($sformatf("cfg%0d_reads_left", g), rq.size(), 0);
            chk($sformatf("cfg%0d_writes_left", g), wq.size(), 0);
            chk($sformatf("cfg%0d_done_count", g), done_cnt, 1);
            chk($sformatf("cfg%0d_done_cycle", g), done_rel, NP + L + 1);
            chk($sformatf("cfg%0d_busy_first", g), busy_first, 1);
            chk($sformatf("cfg%0d_busy_cycles", g), busy_cnt, NP + L + 1);
            chk($sformatf("cfg%0d_busy_after", g), busy, 1'b0);
            bad = 0;
            for (int i = 0; i < NPIX; i++) if (mem[i] !== model[i]) bad++;
            chk($sformatf("cfg%0d_frame_bad_pixels", g), bad, 0);
            if (restore) begin
                bad = 0;
                for (int i = 0; i < NPIX; i++) if (mem[i] !== orig[i]) bad++;
                chk($sformatf("cfg%0d_restore_bad_pixels", g), bad, 0);
            end
        endtask

        initial begin
            bit ab;
            reset = 1'b1;
            start = 1'b0;
            load  = 1'b0;
            repeat (2) @(negedge clk);
            chk($sformatf("cfg%0d_reset_ctrl", g),
                {busy, done, rd0_en, rd1_en, wr0_en, wr1_en, rd0_addr, rd1_addr, wr0_addr, wr1_addr}, '0);
            chk($sformatf("cfg%0d_reset_wdata", g), {wr0_data, wr1_data}, '0);
            reset = 1'b0;
            @(negedge clk);
            load_frame();
            if (cfg_rst(g)) begin
                run_pass(1'b1, 500, ab);
                chk($sformatf("cfg%0d_reset_reached", g), ab, 1'b1);
                rq.delete();
                wq.delete();
                @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                load_frame();
            end
            run_pass(1'b1, 0, ab);
            check_pass(1'b0);
            if (cfg_two(g)) begin
                run_pass(1'b0, 0, ab);
                check_pass(1'b1);
            end
            finished = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(cfg[0].finished && cfg[1].finished && cfg[2].finished &&
                 cfg[3].finished && cfg[4].finished) && n < 60000) begin
            @(posedge clk);
            n++;
        end
        chk("all_configs_finished",
            {cfg[0].finished, cfg[1].finished, cfg[2].finished, cfg[3].finished, cfg[4].finished},
            5'b11111);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
